// File: rtl/jt12_opram_p_if.sv
`default_nettype none
// ============================================================================
//  Module   : jt12_opram_p_if
//  Purpose  : Write/read bus of the parametrised operator-state RAM.
//  Revision : 1.0  initial release
// ============================================================================
interface jt12_opram_p_if #(
    parameter int DW = 44,
    parameter int AW = 5
);
    logic          cen;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] data;
    logic [DW-1:0] q;
    logic          init_busy;

    modport master (
        output cen, wr_en, wr_addr, rd_addr, data,
        input  q, init_busy
    );

    modport slave (
        input  cen, wr_en, wr_addr, rd_addr, data,
        output q, init_busy
    );
endinterface
`default_nettype wire

// File: rtl/jt12_opram_p.sv
`default_nettype none
// ============================================================================
//  Module   : jt12_opram_p
//  Purpose  : Operator-state RAM with clock enable, post-reset init sweep,
//             busy flag and optional write-through (macro JT12_OPRAM_BYPASS_EN).
//  Revision : 1.0  initial release
// ============================================================================
module jt12_opram_p #(
    parameter int            DW       = 44,
    parameter int            AW       = 5,
    parameter logic [DW-1:0] INIT_VAL = {7'h7f, {37{1'b0}}}
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    jt12_opram_p_if.slave    bus
);

    localparam int            c_depth   = 1 << AW;
    localparam logic [AW-1:0] c_last    = '1;
    localparam logic [0:0]    c_st_init = 1'b0;
    localparam logic [0:0]    c_st_run  = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_ram [c_depth];
    logic [DW-1:0] r_q;

    logic          w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [DW-1:0] w_ram_din;
    logic          w_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_init;
        end else if (bus.cen) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_init: if (r_cnt == c_last) w_state_nxt = c_st_run;
            default:   w_state_nxt = c_st_run;
        endcase
    end

    // The sweep owns the write port while in INIT; external writes are dropped.
    always_comb begin
        w_ram_we   = 1'b0;
        w_ram_addr = bus.wr_addr;
        w_ram_din  = bus.data;
        w_busy     = 1'b0;
        case (r_state)
            c_st_init: begin
                w_ram_we   = 1'b1;
                w_ram_addr = r_cnt;
                w_ram_din  = INIT_VAL;
                w_busy     = 1'b1;
            end
            default: begin
                w_ram_we   = bus.wr_en;
            end
        endcase
    end

    // Counter wraps after the last word, but by then the state is RUN so no re-sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (bus.cen && (r_state == c_st_init)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && bus.cen && w_ram_we) begin
            r_ram[w_ram_addr] <= w_ram_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= INIT_VAL;
        end else if (bus.cen) begin
            r_q <= (r_state == c_st_init) ? INIT_VAL : r_ram[bus.rd_addr];
        end
    end

`ifdef JT12_OPRAM_BYPASS_EN
    // Registered collision flag and data steer q around the read-first RAM.
    logic          r_hit;
    logic [DW-1:0] r_byp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit <= 1'b0;
        end else if (bus.cen) begin
            r_hit <= (r_state == c_st_run) && bus.wr_en && (bus.wr_addr == bus.rd_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (bus.cen) begin
            r_byp <= bus.data;
        end
    end

    assign bus.q = r_hit ? r_byp : r_q;
`else
    assign bus.q = r_q;
`endif

    assign bus.init_busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_jt12_opram_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt12_opram_p
//  Purpose  : Self-checking bench for jt12_opram_p (scoreboard on q).
//  Revision : 1.0  initial release
// ============================================================================
module tb_jt12_opram_p;

    localparam logic [43:0] c_init = {7'h7f, 37'h0};

    logic clk;
    logic rst_n;

    jt12_opram_p_if #(.DW(44), .AW(5)) bus ();

    jt12_opram_p #(.DW(44), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [43:0] mem [32];
    logic [43:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; an expected q is queued and compared after the edge.
    task automatic cyc(input string tag, input logic c, input logic we, input logic [4:0] wa,
                       input logic [4:0] ra, input logic [43:0] d, input bit chk,
                       input logic [43:0] exp);
        logic [43:0] e;
        bus.cen     = c;
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.rd_addr = ra;
        bus.data    = d;
        if (chk) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (chk) begin
            e = sb_q.pop_front();
            check(tag, {20'h0, bus.q}, {20'h0, e});
        end
        @(negedge clk);
    endtask

    task automatic reset_dut(input int n);
        rst_n       = 1'b0;
        bus.cen     = 1'b1;
        bus.wr_en   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_q", {20'h0, bus.q}, {20'h0, c_init});
        check("rst_busy", {63'h0, bus.init_busy}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs the sweep from reset release; returns clocks until init_busy falls.
    task automatic sweep(input logic we, input logic [4:0] wa, input logic [43:0] d,
                         input int period, output int n);
        n = 0;
        do begin
            n++;
            bus.cen     = ((n % period) == 0);
            bus.wr_en   = we;
            bus.wr_addr = wa;
            bus.rd_addr = wa;
            bus.data    = d;
            @(posedge clk);
            #1;
            if (n == 5) check("sweep_q", {20'h0, bus.q}, {20'h0, c_init});
            @(negedge clk);
        end while (bus.init_busy && n < 400);
        bus.cen   = 1'b1;
        bus.wr_en = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = c_init;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 32; i++) cyc(tag, 1'b1, 1'b0, 5'd0, 5'(i), 44'h0, 1'b1, mem[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [43:0] va, vb;
        rst_n       = 1'b0;
        bus.cen     = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.rd_addr = '0;
        bus.data    = '0;
        @(negedge clk);

        // Reset, full sweep length, all words initialised
        reset_dut(2);
        sweep(1'b0, 5'd0, 44'h0, 1, n);
        check("busy_len", 64'(n), 64'd32);
        check("busy_low", {63'h0, bus.init_busy}, 64'd0);
        read_all("init_rd");

        // Plain write then read
        cyc("w5", 1'b1, 1'b1, 5'd5, 5'd0, 44'h123_4567_89AB, 1'b1, mem[0]);
        mem[5] = 44'h123_4567_89AB;
        cyc("rd5", 1'b1, 1'b0, 5'd0, 5'd5, 44'h0, 1'b1, mem[5]);
        cyc("rd6", 1'b1, 1'b0, 5'd0, 5'd6, 44'h0, 1'b1, mem[6]);

        // Collision on address 9
        va = 44'hA5A_A5A5_A5A5;
        vb = 44'h5B5_B5B5_B5B5;
        cyc("w9a", 1'b1, 1'b1, 5'd9, 5'd0, va, 1'b0, '0);
        mem[9] = va;
`ifdef JT12_OPRAM_BYPASS_EN
        cyc("coll", 1'b1, 1'b1, 5'd9, 5'd9, vb, 1'b1, vb);
`else
        cyc("coll", 1'b1, 1'b1, 5'd9, 5'd9, vb, 1'b1, va);
`endif
        mem[9] = vb;
        cyc("rd9", 1'b1, 1'b0, 5'd0, 5'd9, 44'h0, 1'b1, mem[9]);

        // Clock enable low: writes ignored, q frozen
        for (int i = 0; i < 10; i++)
            cyc("cen0_q", 1'b0, 1'b1, 5'd3, 5'd3, 44'hCCC_CCCC_CCCC, 1'b1, mem[9]);
        cyc("rd3", 1'b1, 1'b0, 5'd0, 5'd3, 44'h0, 1'b1, mem[3]);

        // Sweep at one enable every third clock
        reset_dut(2);
        sweep(1'b0, 5'd0, 44'h0, 3, n);
        check("busy_len3", 64'(n), 64'd96);

        // Fill with distinct values, then reset again partway through a sweep
        for (int i = 0; i < 32; i++) begin
            cyc("fill", 1'b1, 1'b1, 5'(i), 5'd0, 44'h100 + 44'(i) * 44'h1_0001, 1'b0, '0);
            mem[i] = 44'h100 + 44'(i) * 44'h1_0001;
        end
        cyc("rd17", 1'b1, 1'b0, 5'd0, 5'd17, 44'h0, 1'b1, mem[17]);
        reset_dut(2);
        for (int i = 0; i < 10; i++) cyc("part", 1'b1, 1'b0, 5'd0, 5'd0, 44'h0, 1'b0, '0);
        reset_dut(1);
        sweep(1'b0, 5'd0, 44'h0, 1, n);
        check("busy_len_re", 64'(n), 64'd32);
        read_all("re_rd");

        // Writes during the sweep are dropped
        cyc("w31", 1'b1, 1'b1, 5'd31, 5'd0, 44'h777_0000_1111, 1'b0, '0);
        reset_dut(2);
        sweep(1'b1, 5'd31, 44'hDDD_DDDD_DDDD, 1, n);
        check("busy_len_wr", 64'(n), 64'd32);
        cyc("rd31", 1'b1, 1'b0, 5'd0, 5'd31, 44'h0, 1'b1, mem[31]);
        cyc("rd30", 1'b1, 1'b0, 5'd0, 5'd30, 44'h0, 1'b1, mem[30]);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
